// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin arbiter for eight requesters sharing one 32-bit path.
// Grant is one-hot and registered. control drives the select of the 8:1 word mux.
// Define ARB_TIMEOUT_EN to compile in the hold-time watchdog.
// When the watchdog is present, it forces a release after TIMEOUT_CYCLES grant cycles.
module mux8_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] control,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  offset;
  logic [2:0]  winner;
  logic        release_now;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]  hold_cnt;
  logic        hold_limit;
  assign hold_limit = (hold_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Rotate req so that bit 0 is the requester at ptr. The lowest set bit is the circular winner.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: 8];
    offset  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) offset = 3'(i);
    end
    winner = ptr + offset;
  end

  // The owner is released when it signals done or when it withdraws its request.
  assign release_now = done | ~req[control];

  // Arbitration FSM. Every output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      grant   <= 8'h00;
      control <= 3'd0;
      busy    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req != 8'h00) begin
            state   <= GRANT;
            grant   <= 8'h01 << winner;
            control <= winner;
            busy    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        GRANT: begin
          // control keeps the owner index after release, so the mux select stays stable in IDLE.
          if (release_now) begin
            state <= IDLE;
            grant <= 8'h00;
            busy  <= 1'b0;
            ptr   <= control + 3'd1;
`ifdef ARB_TIMEOUT_EN
          end else if (hold_limit) begin
            state   <= IDLE;
            grant   <= 8'h00;
            busy    <= 1'b0;
            ptr     <= control + 3'd1;
            timeout <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Testbench for mux8_arbiter.
// It runs directed scenarios and then randomized traffic.
// Every output is compared against a round-robin reference model kept in the bench.
// The bench and the model follow ARB_TIMEOUT_EN in the same way as the design.
module tb_mux8_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int TCYC  = 4;
`else
  localparam bit TO_EN = 1'b0;
  localparam int TCYC  = 16;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] control;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int m_owner;   // -1 when nobody owns the path
  int m_ptr;
  int m_ctrl;
  int m_held;    // grant cycles already spent by the current owner
  bit m_to;

  mux8_arbiter #(.TIMEOUT_CYCLES(TCYC)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .control(control), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_ctrl = 0; m_held = 0; m_to = 1'b0;
  endfunction

  // One clock edge of arbitration, written in terms of owner and pointer arithmetic.
  function automatic void model_edge(input logic [7:0] r, input logic d);
    if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_ctrl  = m_owner;
          m_held  = 1;
          break;
        end
      end
    end else if (d || !r[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b0;
    end else if (TO_EN && m_held >= TCYC) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b1;
    end else begin
      m_held++;
      m_to = 1'b0;
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".grant"},   32'(grant),   (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, ".control"}, 32'(control), 32'(m_ctrl));
    check({tag, ".busy"},    32'(busy),    32'(m_owner >= 0));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic step(input logic [7:0] r, input logic d, input string tag);
    req = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    @(negedge clk);
    compare_all(tag);
    $display("%s req=%02h done=%0b -> grant=%02h control=%0d busy=%0b timeout=%0b",
             tag, r, d, grant, control, busy, timeout);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    compare_all("reset");
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all("reset");

    // An idle bus keeps every output at zero.
    for (int i = 0; i < 10; i++) step(8'h00, 1'b0, "idle");

    // Two requesters, starting from ptr 0.
    step(8'h24, 1'b0, "pair_g2");
    check("pair_first", 32'(grant), 32'h04);
    step(8'h24, 1'b1, "pair_rel");
    step(8'h24, 1'b0, "pair_g5");
    check("pair_second", 32'(grant), 32'h20);
    step(8'h24, 1'b1, "pair_rel2");
    step(8'hFF, 1'b0, "pair_ptr6");
    check("pair_ptr6_grant", 32'(grant), 32'h40);
    step(8'hFF, 1'b1, "pair_rel3");

    // Full load from ptr 0. Each grant lasts three edges, then one idle cycle follows.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0, "rr_grant");
      check("rr_order", 32'(grant), 32'd1 << (k % 8));
      step(8'hFF, 1'b0, "rr_hold");
      step(8'hFF, 1'b1, "rr_rel");
      check("rr_idle", 32'(busy), 32'd0);
    end

    // Requester 3 withdraws its request without asserting done.
    step(8'h00, 1'b0, "drop_idle");
    step(8'h08, 1'b0, "drop_g3");
    step(8'h00, 1'b0, "drop_rel");
    check("drop_no_to", 32'(timeout), 32'd0);
    step(8'hFF, 1'b0, "drop_next");
    check("drop_ptr4", 32'(grant), 32'h10);
    step(8'hFF, 1'b1, "drop_rel2");

    // A single holder that never finishes. The watchdog releases it only in the timeout build.
    for (int i = 0; i < TCYC + 3; i++) step(8'h01, 1'b0, "hold");
    step(8'h01, 1'b1, "hold_rel");
    step(8'h00, 1'b0, "hold_idle");

    // Randomized traffic.
    begin
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) r = 8'($urandom);
        step(r, ($urandom_range(0, 4) == 0), "rand");
      end
    end

    // Apply an asynchronous reset mid-grant with owner 6.
    do_reset();
    step(8'h40, 1'b0, "async_g6");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_grant", 32'(grant), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_control", 32'(control), 32'd0);
    #1;
    reset = 1'b0;
    step(8'h41, 1'b0, "async_after");
    check("async_winner0", 32'(grant), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
